// File: rtl/bf_sched_pkg.sv
// Shared types and header field layout for the bloom-filter lookup scheduler.
package bf_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned HDR_W        = 106;
  localparam int unsigned SRC_IP_LSB   = 72;
  localparam int unsigned SRC_IP_W     = 32;
  localparam int unsigned DST_IP_LSB   = 40;
  localparam int unsigned DST_IP_W     = 32;
  localparam int unsigned PROTO_LSB    = 32;
  localparam int unsigned PROTO_W      = 8;
  localparam int unsigned SRC_PORT_LSB = 16;
  localparam int unsigned SRC_PORT_W   = 16;
  localparam int unsigned DST_PORT_LSB = 0;
  localparam int unsigned DST_PORT_W   = 16;

  localparam int unsigned RES_HIT  = 0;
  localparam int unsigned RES_TO   = 1;
  localparam int unsigned RES_PORT = 2;

  typedef struct packed {
    logic [SRC_IP_W-1:0]   src_ip;
    logic [DST_IP_W-1:0]   dst_ip;
    logic [PROTO_W-1:0]    protocol;
    logic [SRC_PORT_W-1:0] src_port;
    logic [DST_PORT_W-1:0] dst_port;
  } hdr_t;

  function automatic hdr_t slice_hdr(input logic [HDR_W-1:0] h);
    hdr_t t;
    t.src_ip   = h[SRC_IP_LSB +: SRC_IP_W];
    t.dst_ip   = h[DST_IP_LSB +: DST_IP_W];
    t.protocol = h[PROTO_LSB +: PROTO_W];
    t.src_port = h[SRC_PORT_LSB +: SRC_PORT_W];
    t.dst_port = h[DST_PORT_LSB +: DST_PORT_W];
    return t;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_ptr_q;

  always_comb begin
    if (&req) begin
      gnt = rr_ptr_q ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (advance) begin
      rr_ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/bf_lookup_sched.sv
// Arbitrates two header requesters onto the shared bloom-filter engine and returns
// a {port, timeout, hit} verdict to the granted requester.
module bf_lookup_sched
  import bf_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HDR_W-1:0] hdr_tdata [2],
  input  logic [1:0]       hdr_tvalid,
  output logic [1:0]       hdr_tready,
  output logic [2:0]       res_tdata,
  output logic [1:0]       res_tvalid,
  input  logic [1:0]       res_tready,
  output logic             need_bf,
  output logic [31:0]      src_ip,
  output logic [31:0]      dst_ip,
  output logic [7:0]       protocol,
  output logic [15:0]      src_port,
  output logic [15:0]      dst_port,
  input  logic             res,
  input  logic             res_sent,
  output logic             busy,
  output logic             stale_res,
  output logic [CNT_W-1:0] cnt_lookups,
  output logic [CNT_W-1:0] cnt_hits,
  output logic [CNT_W-1:0] cnt_timeouts
);

  localparam int unsigned TO_W = 10;

  state_e           state_q, state_d;
  logic [1:0]       gnt;
  logic             accept;
  logic             port_q, port_d;
  hdr_t             tuple_q, tuple_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [2:0]       res_data_q, res_data_d;
  logic [1:0]       res_valid_q, res_valid_d;
  logic             need_bf_q, need_bf_d;
  logic             stale_q, stale_d;
  logic             take_res, expire;
  logic [CNT_W-1:0] cnt_lookups_q, cnt_hits_q, cnt_timeouts_q;

  logic unused_rsvd;
  assign unused_rsvd = ^{hdr_tdata[0][HDR_W-1:HDR_W-2], hdr_tdata[1][HDR_W-1:HDR_W-2]};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (hdr_tvalid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign hdr_tready = (state_q == StIdle) ? gnt : 2'b00;
  assign accept     = |hdr_tready;

  // A strobe on the expiry cycle wins over the timeout.
  assign take_res = res_sent && (state_q == StIssue || state_q == StWait);
  assign expire   = !res_sent && (state_q == StWait) &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    tuple_d     = tuple_q;
    to_cnt_d    = to_cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    need_bf_d   = 1'b0;
    stale_d     = stale_q | (res_sent && (state_q == StIdle || state_q == StResp));

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          port_d    = gnt[1];
          tuple_d   = slice_hdr(hdr_tdata[gnt[1]]);
          need_bf_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (!res_sent) to_cnt_d = to_cnt_q + TO_W'(1);
      end
      StResp: begin
        if (|(res_valid_q & res_tready)) begin
          res_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_res || expire) begin
      state_d               = StResp;
      res_valid_d           = port_q ? 2'b10 : 2'b01;
      res_data_d[RES_PORT]  = port_q;
      res_data_d[RES_TO]    = expire;
      res_data_d[RES_HIT]   = take_res & res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      port_q      <= 1'b0;
      tuple_q     <= '0;
      to_cnt_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= '0;
      need_bf_q   <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      tuple_q     <= tuple_d;
      to_cnt_q    <= to_cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      need_bf_q   <= need_bf_d;
      stale_q     <= stale_d;
    end
  end

  // Statistics counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lookups_q  <= '0;
      cnt_hits_q     <= '0;
      cnt_timeouts_q <= '0;
    end else begin
      if (state_q == StIssue && cnt_lookups_q != '1) begin
        cnt_lookups_q <= cnt_lookups_q + CNT_W'(1);
      end
      if (take_res && res && cnt_hits_q != '1) begin
        cnt_hits_q <= cnt_hits_q + CNT_W'(1);
      end
      if (expire && cnt_timeouts_q != '1) begin
        cnt_timeouts_q <= cnt_timeouts_q + CNT_W'(1);
      end
    end
  end

  assign res_tdata    = res_data_q;
  assign res_tvalid   = res_valid_q;
  assign need_bf      = need_bf_q;
  assign src_ip       = tuple_q.src_ip;
  assign dst_ip       = tuple_q.dst_ip;
  assign protocol     = tuple_q.protocol;
  assign src_port     = tuple_q.src_port;
  assign dst_port     = tuple_q.dst_port;
  assign busy         = (state_q != StIdle);
  assign stale_res    = stale_q;
  assign cnt_lookups  = cnt_lookups_q;
  assign cnt_hits     = cnt_hits_q;
  assign cnt_timeouts = cnt_timeouts_q;

endmodule
